neo_rtc_seq: RTL

Serial sequencer for the uPD4990 calendar/clock chip behind the NEO-F0 RTC pins. The host issues one transaction: an optional 48-bit time write, a 4-bit command, a strobe, and an optional 48-bit time read. The block then generates RTC_DIN, RTC_CLK and RTC_STROBE with fixed bit timing, so the 68K no longer bit-bangs REG_RTCCTRL. It sits between the NEO-F0 register decode and the RTC pins.

---
 rtl/neo_rtc_seq.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/neo_rtc_seq.sv
// neo_rtc_seq: serial sequencer for the uPD4990 RTC (write, command, strobe, read).
// Optional macro NEO_RTC_TP_EDGE_EN adds a synchronized RTC_TP rising-edge pulse on TP_TICK.
module neo_rtc_seq #(
    parameter int unsigned DIV = 8
) (
    input  logic        CLK_12M,
    input  logic        nRESET,
    input  logic        START,
    input  logic [3:0]  CMD,
    input  logic        WR_EN,
    input  logic        RD_EN,
    input  logic [47:0] WDATA,
    output logic [47:0] RDATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        TP_TICK,
    input  logic        RTC_DOUT,
    input  logic        RTC_TP,
    output logic        RTC_DIN,
    output logic        RTC_CLK,
    output logic        RTC_STROBE
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_WSHIFT,
        S_CSHIFT,
        S_STROBE,
        S_RSHIFT,
        S_FINISH
    } state_t;

    localparam logic [7:0] PH_LAST   = 8'(DIV - 1);
    localparam logic [5:0] DATA_LAST = 6'd47;
    localparam logic [5:0] CMD_LAST  = 6'd3;

    state_t      state;
    logic [5:0]  bit_cnt;
    logic [7:0]  ph_cnt;
    logic        half;      // 0 = low half of the bit slot, 1 = high half
    logic [47:0] w_sh;
    logic [3:0]  c_sh;
    logic        rd_q;
    logic        half_end;

    assign half_end = (ph_cnt == PH_LAST);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register here updates from the values present before the clock edge.
    always_ff @(posedge CLK_12M or negedge nRESET) begin
        if (!nRESET) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            ph_cnt     <= '0;
            half       <= 1'b0;
            w_sh       <= '0;
            c_sh       <= '0;
            rd_q       <= 1'b0;
            RDATA      <= '0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            RTC_DIN    <= 1'b0;
            RTC_CLK    <= 1'b0;
            RTC_STROBE <= 1'b0;
        end else begin
            DONE <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (START) begin
                        BUSY    <= 1'b1;
                        rd_q    <= RD_EN;
                        ph_cnt  <= '0;
                        bit_cnt <= '0;
                        half    <= 1'b0;
                        RTC_CLK <= 1'b0;
                        if (WR_EN) begin
                            state   <= S_WSHIFT;
                            RTC_DIN <= WDATA[0];
                            w_sh    <= {1'b0, WDATA[47:1]};
                            c_sh    <= CMD;
                        end else begin
                            state   <= S_CSHIFT;
                            RTC_DIN <= CMD[0];
                            c_sh    <= {1'b0, CMD[3:1]};
                        end
                    end
                end
                S_FINISH: state <= S_IDLE;
                default: begin
                    if (!half_end) begin
                        ph_cnt <= ph_cnt + 8'd1;
                    end else if (!half) begin
                        // End of low half: RTC_CLK rises, read data is sampled just before it.
                        ph_cnt <= '0;
                        half   <= 1'b1;
                        if (state != S_STROBE) RTC_CLK <= 1'b1;
                        if (state == S_RSHIFT) RDATA <= {RTC_DOUT, RDATA[47:1]};
                    end else begin
                        ph_cnt  <= '0;
                        half    <= 1'b0;
                        RTC_CLK <= 1'b0;
                        case (state)
                            S_WSHIFT: begin
                                if (bit_cnt == DATA_LAST) begin
                                    state   <= S_CSHIFT;
                                    bit_cnt <= '0;
                                    RTC_DIN <= c_sh[0];
                                    c_sh    <= {1'b0, c_sh[3:1]};
                                end else begin
                                    bit_cnt <= bit_cnt + 6'd1;
                                    RTC_DIN <= w_sh[0];
                                    w_sh    <= {1'b0, w_sh[47:1]};
                                end
                            end
                            S_CSHIFT: begin
                                if (bit_cnt == CMD_LAST) begin
                                    state      <= S_STROBE;
                                    bit_cnt    <= '0;
                                    RTC_DIN    <= 1'b0;
                                    RTC_STROBE <= 1'b1;
                                end else begin
                                    bit_cnt <= bit_cnt + 6'd1;
                                    RTC_DIN <= c_sh[0];
                                    c_sh    <= {1'b0, c_sh[3:1]};
                                end
                            end
                            S_STROBE: begin
                                RTC_STROBE <= 1'b0;
                                bit_cnt    <= '0;
                                if (rd_q) begin
                                    state <= S_RSHIFT;
                                end else begin
                                    state <= S_FINISH;
                                    BUSY  <= 1'b0;
                                    DONE  <= 1'b1;
                                end
                            end
                            S_RSHIFT: begin
                                if (bit_cnt == DATA_LAST) begin
                                    state   <= S_FINISH;
                                    bit_cnt <= '0;
                                    BUSY    <= 1'b0;
                                    DONE    <= 1'b1;
                                end else begin
                                    bit_cnt <= bit_cnt + 6'd1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

`ifdef NEO_RTC_TP_EDGE_EN
    // tp_sync[1:0] is the synchronizer, tp_sync[2] the previous synchronized level.
    logic [2:0] tp_sync;

    always_ff @(posedge CLK_12M or negedge nRESET) begin
        if (!nRESET) begin
            tp_sync <= '0;
            TP_TICK <= 1'b0;
        end else begin
            tp_sync <= {tp_sync[1:0], RTC_TP};
            TP_TICK <= tp_sync[1] & ~tp_sync[2];
        end
    end
`else
    logic unused_tp;
    assign unused_tp = RTC_TP;
    assign TP_TICK   = 1'b0;
`endif

endmodule
